apb_mem_b_bridge: RTL and testbench
===================================

APB_MEM_B_BRIDGE -- requirements
Module: apb_mem_b_bridge

Interface
REQ-001 SHALL have parameter MEM_WORDS, default MEMORYB_WORDS (21), the number of memory B rows.
REQ-002 SHALL have parameter LANES, default MEMORYB_LANES (3), the number of 32-bit lanes per row.
REQ-003 SHALL have ports clk  input  1  clock, the only clock; rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have APB slave ports psel in 1; penable in 1; pwrite in 1; paddr in apbAddrT (32); pwdata in apbDataT (32); prdata out apbDataT (32); pready out 1; pslverr out 1.
REQ-005 SHALL have memory B master ports mem_cs out 1; mem_we out 1; mem_addr out bAddrBitsT (5); mem_wdata out bMemSt (96); mem_rdata in bMemSt (96), valid exactly one cycle after a read strobe.

Function
REQ-006 SHALL decode paddr[1:0] as ignored, lane = paddr[3:2] and row = paddr[8:4]; paddr[31:9] SHALL be ignored, because the upstream decoder has already qualified them.
REQ-007 SHALL treat lane >= LANES or row >= MEM_WORDS as an illegal access.
REQ-008 SHALL implement states IDLE, RD, WAIT, WR, RESP and ERR.
REQ-009 IDLE: when psel=1 and penable=0, SHALL latch pwrite, pwdata, lane and row, then go to ERR if the access is illegal, otherwise to RD.
REQ-010 RD: SHALL drive mem_cs=1, mem_we=0, mem_addr=row; next state WAIT.
REQ-011 WAIT: SHALL register mem_rdata into a 96-bit row buffer; next state WR if the access is a write, otherwise RESP.
REQ-012 WR: SHALL drive mem_cs=1, mem_we=1, mem_addr=row, mem_wdata=row buffer with the selected lane replaced by the latched pwdata and the other lanes unchanged; next state RESP.
REQ-013 RESP: SHALL drive pready=1 and pslverr=0; prdata SHALL equal the selected buffer lane for a read and 0 for a write; next state IDLE.
REQ-014 ERR: SHALL drive pready=1, pslverr=1, prdata=0; SHALL perform no memory access; next state IDLE.
REQ-015 Outside RESP and ERR, pready SHALL be 0, pslverr SHALL be 0 and prdata SHALL be 0.
REQ-016 Outside RD and WR, mem_cs SHALL be 0 and mem_we SHALL be 0.
REQ-017 Latency, counted from the setup cycle C0: read SHALL assert pready in C3; write in C4; illegal access in C1.
REQ-018 SHALL never accept a new transfer while not in IDLE; back-to-back transfers SHALL each start from IDLE.
REQ-019 If psel deasserts mid-transfer, the transfer SHALL run to completion and pready SHALL still pulse once.
REQ-020 Lane 2 of row 20 SHALL be a legal access; the all-zero address SHALL be a legal access.

Reset
REQ-021 While rst=1, the state SHALL be IDLE and all outputs SHALL be 0; the row buffer and latched fields SHALL be cleared to 0.
REQ-022 When rst asserts in RD, WAIT or WR, no mem_cs SHALL be issued in any cycle after rst is sampled high.
REQ-023 The first transfer after reset release SHALL behave per REQ-009.

Structure
REQ-024 The shared package SHALL hold MEMORYB_LANES = 3, MEMORYB_LANES_LOG2 = 2 and typedef bLaneT (2 bits), alongside the existing bAddrBitsT, bMemSt and apbAddrT/apbDataT.
REQ-025 The bridge SHALL contain no sub-module; lane select and merge SHALL be inline logic.
REQ-026 The memory B macro SHALL be instantiated by the parent, not by the bridge.

Verification
REQ-027 Read hit: memory row 5 preloaded {lane2=0xCCCC0002, lane1=0xBBBB0001, lane0=0xAAAA0000}, APB read paddr=0x54 -> prdata=0xBBBB0001, pslverr=0, pready in C3.
REQ-028 Write merge: same row, write paddr=0x58, pwdata=0x12345678 -> one mem write to addr 5 of {0x12345678, 0xBBBB0001, 0xAAAA0000}; pready in C4.
REQ-029 Illegal lane: paddr=0x0C -> pready and pslverr=1 in C1, prdata=0, mem_cs never asserted.
REQ-030 Illegal row: paddr=0x150 (row 21) -> pslverr=1; paddr=0x148 (row 20, lane 2) -> legal read.
REQ-031 Reset mid-write: assert rst in the WAIT cycle -> no mem_we pulse; outputs 0; a following read of the row returns its original data.
REQ-032 Back-to-back: write lane 0 then immediately read lane 0 of the same row -> the read returns the newly written value.

Source files
------------

// File: rtl/apb_mem_b_bridge_pkg.sv
// Shared types and sizes for the APB to memory B bridge.
// A memory B row is LANES 32-bit words addressed by a 5-bit row index.
package apb_mem_b_bridge_pkg;

    localparam int unsigned MEMORYB_WORDS      = 21;
    localparam int unsigned MEMORYB_LANES      = 3;
    localparam int unsigned MEMORYB_LANES_LOG2 = 2;
    localparam int unsigned MEMORYB_ADDR_BITS  = 5;
    localparam int unsigned LANE_BITS          = 32;

    typedef logic [31:0]                            apbAddrT;
    typedef logic [31:0]                            apbDataT;
    typedef logic [MEMORYB_ADDR_BITS-1:0]           bAddrBitsT;
    typedef logic [MEMORYB_LANES_LOG2-1:0]          bLaneT;
    typedef logic [MEMORYB_LANES*LANE_BITS-1:0]     bMemSt;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StWr,
        StResp,
        StErr
    } bridge_state_e;

endpackage

// File: rtl/apb_mem_b_bridge.sv
// APB slave giving 32-bit lane access to the wide memory B rows.
// Every legal access reads the row first; writes merge one lane and write the row back.
module apb_mem_b_bridge
    import apb_mem_b_bridge_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEMORYB_WORDS,
    parameter int unsigned LANES     = MEMORYB_LANES
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      psel,
    input  logic      penable,
    input  logic      pwrite,
    input  apbAddrT   paddr,
    input  apbDataT   pwdata,
    output apbDataT   prdata,
    output logic      pready,
    output logic      pslverr,
    output logic      mem_cs,
    output logic      mem_we,
    output bAddrBitsT mem_addr,
    output bMemSt     mem_wdata,
    input  bMemSt     mem_rdata
);

    bridge_state_e state_q, state_d;
    logic          write_q;
    apbDataT       wdata_q;
    bLaneT         lane_q;
    bAddrBitsT     row_q;
    bMemSt         buf_q;

    bLaneT     req_lane;
    bAddrBitsT req_row;
    logic      req_setup;
    logic      req_illegal;
    apbDataT   sel_lane;
    bMemSt     merged;
    logic      unused_paddr;

    assign req_lane     = paddr[3:2];
    assign req_row      = paddr[8:4];
    assign req_setup    = psel && !penable;
    assign req_illegal  = (32'(req_lane) >= LANES) || (32'(req_row) >= MEM_WORDS);
    // Upper bits are already qualified by the upstream decoder.
    assign unused_paddr = ^{paddr[31:9], paddr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            wdata_q <= '0;
            lane_q  <= '0;
            row_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_setup) begin
                write_q <= pwrite;
                wdata_q <= pwdata;
                lane_q  <= req_lane;
                row_q   <= req_row;
            end
            if (state_q == StWait) begin
                buf_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_setup) begin
                    state_d = req_illegal ? StErr : StRd;
                end
            end
            StRd:    state_d = StWait;
            StWait:  state_d = write_q ? StWr : StResp;
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sel_lane = '0;
        merged   = buf_q;
        for (int i = 0; i < MEMORYB_LANES; i++) begin
            if (lane_q == bLaneT'(i)) begin
                sel_lane                     = buf_q[i*LANE_BITS +: LANE_BITS];
                merged[i*LANE_BITS +: LANE_BITS] = wdata_q;
            end
        end
    end

    always_comb begin
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            StRd: begin
                mem_cs   = 1'b1;
                mem_addr = row_q;
            end
            StWr: begin
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = row_q;
                mem_wdata = merged;
            end
            StResp: begin
                pready = 1'b1;
                prdata = write_q ? '0 : sel_lane;
            end
            StErr: begin
                pready  = 1'b1;
                pslverr = 1'b1;
            end
            default: ;
        endcase
        // Gate on rst so no strobe escapes in the cycle reset is first sampled.
        if (rst) begin
            prdata    = '0;
            pready    = 1'b0;
            pslverr   = 1'b0;
            mem_cs    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

endmodule

// File: tb/tb_apb_mem_b_bridge.sv
// Scoreboard bench for apb_mem_b_bridge with a behavioural memory B model.
module tb_apb_mem_b_bridge;
    import apb_mem_b_bridge_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    apbAddrT   paddr = '0;
    apbDataT   pwdata = '0;
    apbDataT   prdata;
    logic      pready, pslverr, mem_cs, mem_we;
    bAddrBitsT mem_addr;
    bMemSt     mem_wdata;
    bMemSt     mem_rdata = '0;

    always #5 clk = ~clk;

    apb_mem_b_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory B model: read data one cycle after the strobe.
    bMemSt     mem [MEMORYB_WORDS];
    logic      pre_en = 1'b0;
    bAddrBitsT pre_addr = '0;
    bMemSt     pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_cs && !mem_we) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        apbDataT rdata;
        logic    err;
        int      lat;
        int      setup;
    } rsp_t;

    typedef struct {
        bAddrBitsT addr;
        bMemSt     data;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   cs_count = 0;
    int   we_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [191:0] act,
                                input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops expected responses and memory writes as the DUT presents them.
    always @(negedge clk) begin
        rsp_t e;
        wr_t  w;
        if (mem_cs) cs_count++;
        if (mem_cs && mem_we) we_count++;
        if (pready) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_pready", 192'(pready), 192'(0));
            end else begin
                e = rsp_q.pop_front();
                chk("prdata", 192'(prdata), 192'(e.rdata));
                chk("pslverr", 192'(pslverr), 192'(e.err));
                chk("latency", 192'(cyc - e.setup), 192'(e.lat));
            end
        end else begin
            chk("idle_outputs_zero", {pslverr, prdata}, 192'(0));
        end
        if (mem_cs && mem_we) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_mem_write", 192'(mem_we), 192'(0));
            end else begin
                w = wr_q.pop_front();
                chk("mem_write", {mem_addr, mem_wdata}, {w.addr, w.data});
            end
        end
    end

    task automatic preload(input bAddrBitsT a, input bMemSt d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // One APB transfer; drop=1 releases psel right after the access phase starts.
    task automatic apb(input apbAddrT a, input logic wr, input apbDataT wd,
                       input apbDataT exp_rd, input logic exp_err, input int exp_lat,
                       input logic drop);
        rsp_t e;
        int   n;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.setup = cyc;
        rsp_q.push_back(e);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        if (drop) begin
            @(posedge clk); #1;
            psel = 1'b0; penable = 1'b0;
        end
        n = 0;
        while (!pready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("pready_timeout", 192'(n), 192'(0));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        int cs0;
        int we0;
        wr_t w;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {pready, pslverr, prdata, mem_cs, mem_we, mem_addr, mem_wdata},
            192'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        preload(5'd0,  {32'h0000_0C00, 32'h0000_0B00, 32'hA5A5_0000});
        preload(5'd3,  {32'h3333_0003, 32'h3333_0002, 32'h3333_0001});
        preload(5'd5,  {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000});
        preload(5'd20, {32'h7777_0020, 32'h7777_0010, 32'h7777_0000});

        apb(32'h54, 1'b0, 32'h0, 32'hBBBB_0001, 1'b0, 3, 1'b0);

        w.addr = 5'd5;
        w.data = {32'h1234_5678, 32'hBBBB_0001, 32'hAAAA_0000};
        wr_q.push_back(w);
        apb(32'h58, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 4, 1'b0);

        cs0 = cs_count;
        apb(32'h0C, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b0);
        apb(32'h150, 1'b0, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        chk("illegal_no_mem_cs", 192'(cs_count), 192'(cs0));

        apb(32'h148, 1'b0, 32'h0, 32'h7777_0020, 1'b0, 3, 1'b0);
        apb(32'h0, 1'b0, 32'h0, 32'hA5A5_0000, 1'b0, 3, 1'b0);
        apb(32'hFFFF_FE57, 1'b0, 32'h0, 32'hBBBB_0001, 1'b0, 3, 1'b0);
        apb(32'h58, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 3, 1'b0);

        // Back-to-back write then read of the same lane.
        w.addr = 5'd3;
        w.data = {32'h3333_0003, 32'h3333_0002, 32'h1111_2222};
        wr_q.push_back(w);
        apb(32'h30, 1'b1, 32'h1111_2222, 32'h0, 1'b0, 4, 1'b0);
        apb(32'h30, 1'b0, 32'h0, 32'h1111_2222, 1'b0, 3, 1'b0);

        apb(32'h34, 1'b0, 32'h0, 32'h3333_0002, 1'b0, 3, 1'b1);

        // Reset during the WAIT cycle of a write.
        we0 = we_count;
        cs0 = cs_count;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h50; pwdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_wait_outputs", {pready, pslverr, prdata, mem_cs, mem_we, mem_addr, mem_wdata},
            192'(0));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("rst_held_outputs", {pready, pslverr, prdata, mem_cs, mem_we, mem_addr, mem_wdata},
            192'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_no_mem_we", 192'(we_count), 192'(we0));
        chk("rst_no_mem_cs", 192'(cs_count), 192'(cs0 + 1));
        apb(32'h50, 1'b0, 32'h0, 32'hAAAA_0000, 1'b0, 3, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("rsp_queue_drained", 192'(rsp_q.size()), 192'(0));
        chk("wr_queue_drained", 192'(wr_q.size()), 192'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
